// File: rtl/auc_aluarb.sv
// Round-robin owner arbiter for the shared ECC ALU and block-RAM port.
// The owner's controls are muxed straight through; ownership is held until all issued ALU ops have returned.
module auc_aluarb #(
    parameter int WID   = 256,
    parameter int AWID  = 5,
    parameter int OPWID = 4,
    parameter int NREQ  = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ-1:0]        rel_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   busy_o,
    output logic                   err_o,
    input  logic [NREQ*OPWID-1:0]  cl_opcode_i,
    input  logic [NREQ-1:0]        cl_auen_i,
    input  logic [NREQ-1:0]        cl_carry_i,
    input  logic [NREQ-1:0]        cl_swapvl_i,
    input  logic [NREQ-1:0]        cl_swapop_i,
    input  logic [NREQ*AWID-1:0]   cl_ra_i,
    input  logic [NREQ*AWID-1:0]   cl_wa_i,
    input  logic [NREQ-1:0]        cl_we_i,
    input  logic [NREQ*WID-1:0]    cl_wd_i,
    output logic [NREQ-1:0]        cl_auvld_o,
    output logic [OPWID-1:0]       au_opcode_o,
    output logic                   au_auen_o,
    output logic                   au_carry_o,
    output logic                   au_swapvl_o,
    output logic                   au_swapop_o,
    input  logic                   au_vld_i,
    output logic [AWID-1:0]        ram_ra_o,
    output logic [AWID-1:0]        ram_wa_o,
    output logic                   ram_we_o,
    output logic [WID-1:0]         ram_wd_o
);

    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rrPtr_q, rrPtr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            err_q, err_d;

    logic [IW-1:0]   winner;
    logic [IW-1:0]   ownerNext;
    logic            found;
    logic            owned;
    logic            selAuen;
    logic            selWe;
    logic            relOwner;
    logic            auDec;

    assign owned     = (state_q != IDLE);
    assign relOwner  = |(rel_i & gnt_q);
    assign ownerNext = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

    // Owner-to-shared-resource mux; everything reads as zero with no owner.
    always_comb begin
        au_opcode_o = '0;
        au_carry_o  = 1'b0;
        au_swapvl_o = 1'b0;
        au_swapop_o = 1'b0;
        ram_ra_o    = '0;
        ram_wa_o    = '0;
        ram_wd_o    = '0;
        selAuen     = 1'b0;
        selWe       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owned && owner_q == IW'(i)) begin
                au_opcode_o = cl_opcode_i[i*OPWID +: OPWID];
                au_carry_o  = cl_carry_i[i];
                au_swapvl_o = cl_swapvl_i[i];
                au_swapop_o = cl_swapop_i[i];
                ram_ra_o    = cl_ra_i[i*AWID +: AWID];
                ram_wa_o    = cl_wa_i[i*AWID +: AWID];
                ram_wd_o    = cl_wd_i[i*WID +: WID];
                selAuen     = cl_auen_i[i];
                selWe       = cl_we_i[i];
            end
        end
    end

    // Strobes pass only in OWN; a full in-flight counter stalls the start pulse.
    assign au_auen_o  = (state_q == OWN) && selAuen && (cnt_q != 2'd3);
    assign ram_we_o   = (state_q == OWN) && selWe;
    assign auDec      = au_vld_i && (cnt_q != 2'd0);
    assign cl_auvld_o = au_vld_i ? gnt_q : '0;

    always_comb begin
        cnt_d = cnt_q;
        case ({au_auen_o, auDec})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req_i[(int'(rrPtr_q) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IW'((int'(rrPtr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        rrPtr_d = rrPtr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = NREQ'(1) << winner;
                    owner_d = winner;
                end
            end
            OWN: begin
                if (relOwner) begin
                    if (cnt_d == 2'd0) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        rrPtr_d = ownerNext;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (cnt_d == 2'd0) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    rrPtr_d = ownerNext;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign err_d = err_q
                 | (|((cl_auen_i | cl_we_i | rel_i) & ~gnt_q))
                 | (au_vld_i && (cnt_q == 2'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            rrPtr_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            rrPtr_q <= rrPtr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = owned;
    assign err_o  = err_q;

endmodule

// File: tb/tb_auc_aluarb.sv
// Directed bench for auc_aluarb: ALU starts and routed result-valids are scoreboarded,
// grant/busy/err and mux outputs are compared against hand-computed values.
module tb_auc_aluarb;

    localparam int WID   = 16;
    localparam int AWID  = 5;
    localparam int OPWID = 4;
    localparam int NREQ  = 3;

    typedef struct packed {
        logic [OPWID-1:0] op;
        logic [AWID-1:0]  ra;
    } auExp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req, rel, clAuen, clWe;
    logic [NREQ-1:0]       clCarry, clSwapvl, clSwapop;
    logic [NREQ*OPWID-1:0] clOpcode;
    logic [NREQ*AWID-1:0]  clRa, clWa;
    logic [NREQ*WID-1:0]   clWd;
    logic                  auVld;
    logic [NREQ-1:0]       gnt, clAuvld;
    logic                  busy, err;
    logic [OPWID-1:0]      auOpcode;
    logic                  auAuen, auCarry, auSwapvl, auSwapop;
    logic [AWID-1:0]       ramRa, ramWa;
    logic                  ramWe;
    logic [WID-1:0]        ramWd;

    auExp_t          expAuQ[$];
    logic [NREQ-1:0] expVldQ[$];
    int              checks = 0;
    int              errors = 0;

    auc_aluarb #(.WID(WID), .AWID(AWID), .OPWID(OPWID), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst),
        .req_i(req), .rel_i(rel), .gnt_o(gnt), .busy_o(busy), .err_o(err),
        .cl_opcode_i(clOpcode), .cl_auen_i(clAuen), .cl_carry_i(clCarry),
        .cl_swapvl_i(clSwapvl), .cl_swapop_i(clSwapop),
        .cl_ra_i(clRa), .cl_wa_i(clWa), .cl_we_i(clWe), .cl_wd_i(clWd),
        .cl_auvld_o(clAuvld), .au_opcode_o(auOpcode), .au_auen_o(auAuen),
        .au_carry_o(auCarry), .au_swapvl_o(auSwapvl), .au_swapop_o(auSwapop),
        .au_vld_i(auVld), .ram_ra_o(ramRa), .ram_wa_o(ramWa),
        .ram_we_o(ramWe), .ram_wd_o(ramWd)
    );

    always #5 clk = ~clk;

    // Fixed per-client control values; client i has opcode/ra below.
    function automatic logic [OPWID-1:0] opOf(input int i);
        case (i)
            0:       return 4'h3;
            1:       return 4'h5;
            default: return 4'h9;
        endcase
    endfunction

    function automatic logic [AWID-1:0] raOf(input int i);
        case (i)
            0:       return 5'd7;
            1:       return 5'd11;
            default: return 5'd22;
        endcase
    endfunction

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ-1:0] rl,
                                 input logic [NREQ-1:0] ae, input logic [NREQ-1:0] we,
                                 input logic v);
        req    = r;
        rel    = rl;
        clAuen = ae;
        clWe   = we;
        auVld  = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushAu(input int i);
        auExp_t e;
        e.op = opOf(i);
        e.ra = raOf(i);
        expAuQ.push_back(e);
    endtask

    task automatic resetDut();
        applyStimulus('0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Scoreboard monitor: each ALU start and each routed result-valid pops one expectation.
    initial begin
        auExp_t          e;
        logic [NREQ-1:0] v;
        forever begin
            @(negedge clk);
            #3;
            if (auAuen) begin
                checks++;
                if (expAuQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL au_auen unexpected: got op %0h ra %0d expected none", auOpcode, ramRa);
                end else begin
                    e = expAuQ.pop_front();
                    if (auOpcode !== e.op || ramRa !== e.ra) begin
                        errors++;
                        $display("[TB] FAIL au_auen route: got op %0h ra %0d expected op %0h ra %0d",
                                 auOpcode, ramRa, e.op, e.ra);
                    end
                end
            end
            if (clAuvld != '0) begin
                checks++;
                if (expVldQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL cl_auvld unexpected: got %b expected none", clAuvld);
                end else begin
                    v = expVldQ.pop_front();
                    if (clAuvld !== v) begin
                        errors++;
                        $display("[TB] FAIL cl_auvld route: got %b expected %b", clAuvld, v);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clOpcode = {4'h9, 4'h5, 4'h3};
        clRa     = {5'd22, 5'd11, 5'd7};
        clWa     = {5'd30, 5'd20, 5'd10};
        clWd     = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        clCarry  = 3'b010;
        clSwapvl = 3'b100;
        clSwapop = 3'b001;
        applyStimulus('0, '0, '0, '0, 1'b0);
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        checkOutput("reset gnt", 32'(gnt), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset err", 32'(err), 32'h0);

        // Single client: grant, one op, result routed, release.
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        cyc();
        checkOutput("t1 gnt", 32'(gnt), 32'h1);
        checkOutput("t1 busy", 32'(busy), 32'h1);
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        pushAu(0);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        repeat (4) cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b1);
        expVldQ.push_back(3'b001);
        cyc();
        applyStimulus(3'b001, 3'b001, '0, '0, 1'b0);
        checkOutput("t1 gnt before rel", 32'(gnt), 32'h1);
        cyc();
        checkOutput("t1 gnt after rel", 32'(gnt), 32'h0);
        checkOutput("t1 busy after rel", 32'(busy), 32'h0);
        applyStimulus('0, '0, '0, '0, 1'b0);
        cyc();

        // All three request continuously: round-robin order 0,1,2,0.
        resetDut();
        applyStimulus(3'b111, '0, '0, '0, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            int              e;
            logic [NREQ-1:0] oh;
            e  = k % NREQ;
            oh = 3'b001 << e;
            checkOutput($sformatf("t2 grant %0d", k), 32'(gnt), 32'(oh));
            applyStimulus(3'b111, '0, oh, '0, 1'b0);
            pushAu(e);
            cyc();
            applyStimulus(3'b111, '0, '0, '0, 1'b1);
            expVldQ.push_back(oh);
            cyc();
            applyStimulus(3'b111, oh, '0, '0, 1'b0);
            checkOutput($sformatf("t2 held %0d", k), 32'(gnt), 32'(oh));
            cyc();
            checkOutput($sformatf("t2 gap %0d", k), 32'(gnt), 32'h0);
            if (k == 3) applyStimulus('0, '0, '0, '0, 1'b0);
            else        applyStimulus(3'b111, '0, '0, '0, 1'b0);
            cyc();
        end
        checkOutput("t2 err", 32'(err), 32'h0);

        // Release with two ops in flight: DRAIN masks starts and holds grant.
        resetDut();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        cyc();
        checkOutput("t3 gnt", 32'(gnt), 32'h1);
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        pushAu(0);
        cyc();
        pushAu(0);
        cyc();
        applyStimulus(3'b001, 3'b001, '0, '0, 1'b0);
        cyc();
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        settle();
        checkOutput("t3 auen masked", 32'(auAuen), 32'h0);
        checkOutput("t3 busy drain", 32'(busy), 32'h1);
        checkOutput("t3 gnt drain", 32'(gnt), 32'h1);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b1);
        expVldQ.push_back(3'b001);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        checkOutput("t3 gnt after 1st vld", 32'(gnt), 32'h1);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b1);
        expVldQ.push_back(3'b001);
        cyc();
        applyStimulus('0, '0, '0, '0, 1'b0);
        checkOutput("t3 gnt released", 32'(gnt), 32'h0);
        checkOutput("t3 busy released", 32'(busy), 32'h0);
        checkOutput("t3 err", 32'(err), 32'h0);

        // Four back-to-back starts: third fills the counter, fourth waits for a result.
        resetDut();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        cyc();
        checkOutput("t4 gnt", 32'(gnt), 32'h1);
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        pushAu(0);
        cyc();
        pushAu(0);
        cyc();
        pushAu(0);
        cyc();
        settle();
        checkOutput("t4 stall", 32'(auAuen), 32'h0);
        cyc();
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b1);
        expVldQ.push_back(3'b001);
        settle();
        checkOutput("t4 stall during vld", 32'(auAuen), 32'h0);
        cyc();
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        pushAu(0);
        settle();
        checkOutput("t4 fourth accepted", 32'(auAuen), 32'h1);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        cyc();

        // RAM write routing, then a non-owner write sets the sticky error.
        resetDut();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        cyc();
        checkOutput("t5 gnt", 32'(gnt), 32'h1);
        applyStimulus(3'b001, '0, '0, 3'b001, 1'b0);
        settle();
        checkOutput("t5 owner we", 32'(ramWe), 32'h1);
        checkOutput("t5 owner wa", 32'(ramWa), 32'd10);
        checkOutput("t5 owner wd", 32'(ramWd), 32'hAAAA);
        checkOutput("t5 owner carry", 32'({auCarry, auSwapvl, auSwapop}), 32'b001);
        cyc();
        applyStimulus(3'b001, '0, '0, 3'b010, 1'b0);
        checkOutput("t5 err before", 32'(err), 32'h0);
        settle();
        checkOutput("t5 non-owner we", 32'(ramWe), 32'h0);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        checkOutput("t5 err set", 32'(err), 32'h1);
        repeat (3) cyc();
        checkOutput("t5 err sticky", 32'(err), 32'h1);

        // Reset with one op in flight clears everything including the counter.
        applyStimulus(3'b001, '0, 3'b001, '0, 1'b0);
        pushAu(0);
        cyc();
        applyStimulus(3'b001, '0, '0, '0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checkOutput("t6 gnt", 32'(gnt), 32'h0);
        checkOutput("t6 busy", 32'(busy), 32'h0);
        checkOutput("t6 err", 32'(err), 32'h0);
        cyc();
        checkOutput("t6 regrant", 32'(gnt), 32'h1);
        applyStimulus(3'b001, 3'b001, '0, '0, 1'b0);
        cyc();
        checkOutput("t6 cnt cleared", 32'(gnt), 32'h0);
        applyStimulus('0, '0, '0, 3'b111, 1'b0);
        settle();
        checkOutput("t6 idle we", 32'(ramWe), 32'h0);
        checkOutput("t6 idle opcode", 32'(auOpcode), 32'h0);
        checkOutput("t6 idle wa", 32'(ramWa), 32'h0);
        cyc();
        applyStimulus('0, '0, '0, '0, 1'b0);
        checkOutput("t6 idle we err", 32'(err), 32'h1);
        cyc();
        cyc();

        checkOutput("auen queue empty", 32'(expAuQ.size()), 32'h0);
        checkOutput("vld queue empty", 32'(expVldQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
